// File: rtl/ray_dispatch_ctrl.sv
// ray_dispatch_ctrl
//   Sequences one ambient-occlusion frame over NUM_LANES traversal lanes.
//   Ray IDs 0..num_rays-1 are handed to idle lanes (at most one load per
//   cycle, round-robin). Lane completions are arbitrated round-robin onto a
//   single registered result port. The frame cycle counter runs while busy,
//   and the controller reports DONE once every ray has retired.
//
// Ports
//   clock, reset        clock; synchronous active-high reset
//   start_i, num_rays_i frame start pulse (honoured in IDLE/DONE) and ray count
//   disp_*              per-lane ray issue (valid/ready, ID packed by lane)
//   cmpl_*              per-lane completion (ID, fp32 hit distance, ready)
//   res_*               arbitrated result stream (registered valid/ID/hitT)
//   busy_o, finish_o    RUN or DRAIN / DONE
//   rays_done_o         completions accepted this frame
//   cycle_count_o       RUN+DRAIN cycles this frame, saturating
//
// state   | meaning
// S_IDLE  | waiting for first start after reset
// S_RUN   | issuing ray IDs to idle lanes
// S_DRAIN | all IDs handed out, waiting for issues/completions to retire
// S_DONE  | frame complete; counters frozen until next start
module ray_dispatch_ctrl #(
  parameter int NUM_LANES = 2,
  parameter int ID_W      = 32,
  parameter int CNT_W     = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic [ID_W-1:0]           num_rays_i,
  output logic [NUM_LANES-1:0]      disp_valid_o,
  output logic [NUM_LANES*ID_W-1:0] disp_ray_id_o,
  input  logic [NUM_LANES-1:0]      disp_ready_i,
  input  logic [NUM_LANES-1:0]      cmpl_valid_i,
  input  logic [NUM_LANES*ID_W-1:0] cmpl_ray_id_i,
  input  logic [NUM_LANES*32-1:0]   cmpl_hitT_i,
  output logic [NUM_LANES-1:0]      cmpl_ready_o,
  output logic                      res_valid_o,
  output logic [ID_W-1:0]           res_ray_id_o,
  output logic [31:0]               res_hitT_o,
  input  logic                      res_ready_i,
  output logic                      busy_o,
  output logic                      finish_o,
  output logic [ID_W-1:0]           rays_done_o,
  output logic [CNT_W-1:0]          cycle_count_o
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [ID_W-1:0]           num_rays_q, num_rays_d;
  logic [ID_W-1:0]           next_id_q, next_id_d;
  logic [ID_W-1:0]           rays_done_q, rays_done_d;
  logic [CNT_W-1:0]          cycle_count_q, cycle_count_d;
  logic [PTR_W-1:0]          d_ptr_q, d_ptr_d;
  logic [PTR_W-1:0]          c_ptr_q, c_ptr_d;
  logic [NUM_LANES-1:0]      disp_valid_q, disp_valid_d;
  logic [NUM_LANES*ID_W-1:0] disp_ray_id_q, disp_ray_id_d;
  logic                      res_valid_q, res_valid_d;
  logic [ID_W-1:0]           res_ray_id_q, res_ray_id_d;
  logic [31:0]               res_hitT_q, res_hitT_d;

  logic             start_ok, busy;
  logic             load_en, grant_en, cmpl_xfer;
  logic [PTR_W-1:0] load_lane, grant, idx;

  always_comb begin
    state_d       = state_q;
    num_rays_d    = num_rays_q;
    next_id_d     = next_id_q;
    rays_done_d   = rays_done_q;
    cycle_count_d = cycle_count_q;
    d_ptr_d       = d_ptr_q;
    c_ptr_d       = c_ptr_q;
    res_valid_d   = res_valid_q;
    res_ray_id_d  = res_ray_id_q;
    res_hitT_d    = res_hitT_q;
    disp_ray_id_d = disp_ray_id_q;
    cmpl_ready_o  = '0;
    idx           = '0;
    load_en       = 1'b0;
    load_lane     = '0;
    grant_en      = 1'b0;
    grant         = '0;

    start_ok = start_i && (state_q == S_IDLE || state_q == S_DONE);
    busy     = (state_q == S_RUN) || (state_q == S_DRAIN);

    // Lanes that hand off their ray this edge are only reloadable next edge,
    // so the candidate search looks at the registered valid bits.
    disp_valid_d = disp_valid_q & ~disp_ready_i;

    if (state_q == S_RUN && next_id_q != num_rays_q) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        idx = PTR_W'((int'(d_ptr_q) + k) % NUM_LANES);
        if (!load_en && !disp_valid_q[idx]) begin
          load_en   = 1'b1;
          load_lane = idx;
        end
      end
    end

    if (load_en) begin
      disp_valid_d[load_lane]                        = 1'b1;
      disp_ray_id_d[int'(load_lane)*ID_W +: ID_W]    = next_id_q;
      next_id_d                                      = next_id_q + ID_W'(1);
      d_ptr_d = PTR_W'((int'(load_lane) + 1) % NUM_LANES);
    end

    if (busy) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        idx = PTR_W'((int'(c_ptr_q) + k) % NUM_LANES);
        if (!grant_en && cmpl_valid_i[idx]) begin
          grant_en = 1'b1;
          grant    = idx;
        end
      end
    end

    // Result slot is reusable in the same cycle it drains: full throughput.
    cmpl_xfer = grant_en && (!res_valid_q || res_ready_i);
    if (cmpl_xfer) begin
      cmpl_ready_o[grant] = 1'b1;
      res_valid_d         = 1'b1;
      res_ray_id_d        = cmpl_ray_id_i[int'(grant)*ID_W +: ID_W];
      res_hitT_d          = cmpl_hitT_i[int'(grant)*32 +: 32];
      rays_done_d         = rays_done_q + ID_W'(1);
      c_ptr_d             = PTR_W'((int'(grant) + 1) % NUM_LANES);
    end else if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end

    if (busy && cycle_count_q != '1) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end

    case (state_q)
      S_RUN:   if (next_id_q == num_rays_q) state_d = S_DRAIN;
      S_DRAIN: if (rays_done_q == num_rays_q && !res_valid_q) state_d = S_DONE;
      default: ;
    endcase

    if (start_ok) begin
      num_rays_d    = num_rays_i;
      next_id_d     = '0;
      rays_done_d   = '0;
      cycle_count_d = '0;
      state_d       = (num_rays_i == '0) ? S_DONE : S_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      num_rays_q    <= '0;
      next_id_q     <= '0;
      rays_done_q   <= '0;
      cycle_count_q <= '0;
      d_ptr_q       <= '0;
      c_ptr_q       <= '0;
      disp_valid_q  <= '0;
      disp_ray_id_q <= '0;
      res_valid_q   <= 1'b0;
      res_ray_id_q  <= '0;
      res_hitT_q    <= '0;
    end else begin
      state_q       <= state_d;
      num_rays_q    <= num_rays_d;
      next_id_q     <= next_id_d;
      rays_done_q   <= rays_done_d;
      cycle_count_q <= cycle_count_d;
      d_ptr_q       <= d_ptr_d;
      c_ptr_q       <= c_ptr_d;
      disp_valid_q  <= disp_valid_d;
      disp_ray_id_q <= disp_ray_id_d;
      res_valid_q   <= res_valid_d;
      res_ray_id_q  <= res_ray_id_d;
      res_hitT_q    <= res_hitT_d;
    end
  end

  assign disp_valid_o  = disp_valid_q;
  assign disp_ray_id_o = disp_ray_id_q;
  assign res_valid_o   = res_valid_q;
  assign res_ray_id_o  = res_ray_id_q;
  assign res_hitT_o    = res_hitT_q;
  assign busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign finish_o      = (state_q == S_DONE);
  assign rays_done_o   = rays_done_q;
  assign cycle_count_o = cycle_count_q;

endmodule

// File: tb/tb_ray_dispatch_ctrl.sv
module tb_ray_dispatch_ctrl;
  localparam int NL = 2;
  localparam int IW = 32;
  localparam int CW = 64;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [IW-1:0]  num_rays;
  logic [NL-1:0]  disp_valid, disp_ready, cmpl_valid, cmpl_ready;
  logic [NL*IW-1:0] disp_ray_id, cmpl_ray_id;
  logic [NL*32-1:0] cmpl_hitT;
  logic           res_valid, res_ready, busy, finish;
  logic [IW-1:0]  res_ray_id, rays_done;
  logic [31:0]    res_hitT;
  logic [CW-1:0]  cycle_count;

  int checks = 0;
  int errors = 0;

  // lane emulation state for the round-trip frame
  int q_id [NL][$];
  int q_due [NL][$];
  int iss_lane [$];
  int iss_id [$];
  int did [NL];
  logic [NL-1:0] dx, cx;
  logic rx;
  logic [IW-1:0] rid;
  logic [31:0] rh;
  logic [3:0] seen;
  int cyc, res_n, dup, hbad;

  always #5 clock = ~clock;

  ray_dispatch_ctrl #(.NUM_LANES(NL), .ID_W(IW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start_i(start), .num_rays_i(num_rays),
    .disp_valid_o(disp_valid), .disp_ray_id_o(disp_ray_id), .disp_ready_i(disp_ready),
    .cmpl_valid_i(cmpl_valid), .cmpl_ray_id_i(cmpl_ray_id), .cmpl_hitT_i(cmpl_hitT),
    .cmpl_ready_o(cmpl_ready), .res_valid_o(res_valid), .res_ray_id_o(res_ray_id),
    .res_hitT_o(res_hitT), .res_ready_i(res_ready), .busy_o(busy), .finish_o(finish),
    .rays_done_o(rays_done), .cycle_count_o(cycle_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; num_rays = '0; disp_ready = '0;
    cmpl_valid = '0; cmpl_ray_id = '0; cmpl_hitT = '0; res_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic [IW-1:0] n);
    start = 1'b1; num_rays = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state; a completion offered in IDLE must not be acked
    do_reset();
    cmpl_valid = 2'b11;
    #1;
    chk("rst_disp_valid", 64'(disp_valid), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_finish", 64'(finish), 64'd0);
    chk("rst_rays_done", 64'(rays_done), 64'd0);
    chk("rst_cycle_count", cycle_count, 64'd0);
    chk("idle_cmpl_ready", 64'(cmpl_ready), 64'd0);

    // frame of 4 rays, lanes always ready, 3-cycle completion
    do_reset();
    disp_ready = 2'b11;
    start_frame(32'd4);
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    chk("t1_no_disp_at_start", 64'(disp_valid), 64'd0);
    cyc = 0; res_n = 0; dup = 0; hbad = 0; seen = '0;
    while (!finish && cyc < 60) begin
      for (int i = 0; i < NL; i++) begin
        if (q_id[i].size() > 0 && q_due[i][0] <= cyc) begin
          cmpl_valid[i] = 1'b1;
          cmpl_ray_id[i*IW +: IW] = 32'(q_id[i][0]);
          cmpl_hitT[i*32 +: 32] = 32'(q_id[i][0]) + 32'h100;
        end else begin
          cmpl_valid[i] = 1'b0;
        end
      end
      #1;
      dx = disp_valid & disp_ready;
      cx = cmpl_valid & cmpl_ready;
      for (int i = 0; i < NL; i++) did[i] = int'(disp_ray_id[i*IW +: IW]);
      rx = res_valid & res_ready;
      rid = res_ray_id;
      rh = res_hitT;
      tick();
      cyc++;
      for (int i = 0; i < NL; i++) begin
        if (cx[i]) begin
          void'(q_id[i].pop_front());
          void'(q_due[i].pop_front());
        end
        if (dx[i]) begin
          iss_lane.push_back(i);
          iss_id.push_back(did[i]);
          q_id[i].push_back(did[i]);
          q_due[i].push_back(cyc + 2);
        end
      end
      if (rx) begin
        res_n++;
        if (rid < 4) begin
          if (seen[rid[1:0]]) dup++;
          seen[rid[1:0]] = 1'b1;
        end else begin
          dup++;
        end
        if (rh != rid + 32'h100) hbad++;
      end
    end
    cmpl_valid = '0;
    chk("t1_finish", 64'(finish), 64'd1);
    chk("t1_issue_count", 64'(iss_lane.size()), 64'd4);
    for (int k = 0; k < iss_lane.size() && k < 4; k++) begin
      chk("t1_issue_lane", 64'(iss_lane[k]), 64'(k % 2));
      chk("t1_issue_id", 64'(iss_id[k]), 64'(k));
    end
    chk("t1_res_count", 64'(res_n), 64'd4);
    chk("t1_res_seen", 64'(seen), 64'hF);
    chk("t1_res_dup", 64'(dup), 64'd0);
    chk("t1_res_hitT", 64'(hbad), 64'd0);
    chk("t1_rays_done", 64'(rays_done), 64'd4);
    chk("t1_cycle_count", cycle_count, 64'd10);
    chk("t1_busy_done", 64'(busy), 64'd0);

    // empty frame
    do_reset();
    start_frame(32'd0);
    chk("t2_finish", 64'(finish), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    chk("t2_disp_valid", 64'(disp_valid), 64'd0);
    chk("t2_cycle_count", cycle_count, 64'd0);
    cmpl_valid = 2'b11;
    tick();
    chk("t2_done_cmpl_ready", 64'(cmpl_ready), 64'd0);
    chk("t2_cycle_frozen", cycle_count, 64'd0);
    chk("t2_still_finish", 64'(finish), 64'd1);

    // both lanes completing every cycle, then result back-pressure
    do_reset();
    cmpl_valid = 2'b11;
    cmpl_ray_id = {32'h0000_00B1, 32'h0000_00A0};
    cmpl_hitT = {32'h4000_0000, 32'h3F80_0000};
    start_frame(32'd100);
    chk("t3_grant0", 64'(cmpl_ready), 64'd1);
    tick();
    chk("t3_res_a0", 64'(res_ray_id), 64'hA0);
    chk("t3_hit_a0", 64'(res_hitT), 64'h3F80_0000);
    chk("t3_res_valid", 64'(res_valid), 64'd1);
    chk("t3_done1", 64'(rays_done), 64'd1);
    chk("t3_grant1", 64'(cmpl_ready), 64'd2);
    tick();
    chk("t3_res_b1", 64'(res_ray_id), 64'hB1);
    chk("t3_hit_b1", 64'(res_hitT), 64'h4000_0000);
    chk("t3_done2", 64'(rays_done), 64'd2);
    chk("t3_grant0b", 64'(cmpl_ready), 64'd1);
    tick();
    chk("t3_res_a0b", 64'(res_ray_id), 64'hA0);
    chk("t3_done3", 64'(rays_done), 64'd3);
    tick();
    chk("t3_res_b1b", 64'(res_ray_id), 64'hB1);
    chk("t3_done4", 64'(rays_done), 64'd4);
    res_ready = 1'b0;
    #1;
    chk("t4_stall_cmpl_ready", 64'(cmpl_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_stall_res_id", 64'(res_ray_id), 64'hB1);
      chk("t4_stall_res_valid", 64'(res_valid), 64'd1);
      chk("t4_stall_done", 64'(rays_done), 64'd4);
      chk("t4_stall_ready", 64'(cmpl_ready), 64'd0);
    end
    res_ready = 1'b1;
    #1;
    chk("t4_release_grant", 64'(cmpl_ready), 64'd1);
    tick();
    chk("t4_resume_a0", 64'(res_ray_id), 64'hA0);
    chk("t4_resume_done5", 64'(rays_done), 64'd5);
    tick();
    chk("t4_resume_b1", 64'(res_ray_id), 64'hB1);
    chk("t4_resume_done6", 64'(rays_done), 64'd6);
    cmpl_valid = '0;

    // lane1 never ready: holds ID 1 while lane0 takes 0 and 2
    do_reset();
    disp_ready = 2'b01;
    start_frame(32'd3);
    tick();
    chk("t5_e1_valid", 64'(disp_valid), 64'd1);
    chk("t5_e1_id0", 64'(disp_ray_id[31:0]), 64'd0);
    tick();
    chk("t5_e2_valid", 64'(disp_valid), 64'd2);
    chk("t5_e2_id1", 64'(disp_ray_id[63:32]), 64'd1);
    tick();
    chk("t5_e3_valid", 64'(disp_valid), 64'd3);
    chk("t5_e3_lane0", 64'(disp_ray_id[31:0]), 64'd2);
    chk("t5_e3_lane1", 64'(disp_ray_id[63:32]), 64'd1);
    tick();
    chk("t5_e4_valid", 64'(disp_valid), 64'd2);
    chk("t5_e4_busy", 64'(busy), 64'd1);
    cmpl_valid = 2'b01; cmpl_ray_id = {32'd0, 32'd0};
    tick();
    chk("t5_res0", 64'(res_ray_id), 64'd0);
    chk("t5_done1", 64'(rays_done), 64'd1);
    cmpl_ray_id = {32'd0, 32'd2};
    tick();
    chk("t5_res2", 64'(res_ray_id), 64'd2);
    chk("t5_done2", 64'(rays_done), 64'd2);
    cmpl_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    chk("t5_drain_busy", 64'(busy), 64'd1);
    chk("t5_drain_finish", 64'(finish), 64'd0);
    chk("t5_drain_valid", 64'(disp_valid), 64'd2);
    chk("t5_drain_id1", 64'(disp_ray_id[63:32]), 64'd1);
    disp_ready = 2'b11;
    tick();
    chk("t5_lane1_taken", 64'(disp_valid), 64'd0);
    cmpl_valid = 2'b10; cmpl_ray_id = {32'd1, 32'd0};
    tick();
    chk("t5_res1", 64'(res_ray_id), 64'd1);
    chk("t5_done3", 64'(rays_done), 64'd3);
    cmpl_valid = '0;
    tick();
    chk("t5_res_cleared", 64'(res_valid), 64'd0);
    chk("t5_not_yet_done", 64'(finish), 64'd0);
    tick();
    chk("t5_finish", 64'(finish), 64'd1);
    chk("t5_cycle_count", cycle_count, 64'd14);

    // reset mid-frame, then a fresh frame
    do_reset();
    disp_ready = 2'b11;
    start_frame(32'd5);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t6_rst_disp_valid", 64'(disp_valid), 64'd0);
    chk("t6_rst_disp_id", disp_ray_id, 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_finish", 64'(finish), 64'd0);
    chk("t6_rst_res_valid", 64'(res_valid), 64'd0);
    chk("t6_rst_cycle_count", cycle_count, 64'd0);
    reset = 1'b0;
    start_frame(32'd2);
    chk("t6_busy", 64'(busy), 64'd1);
    tick();
    chk("t6_e1_valid", 64'(disp_valid), 64'd1);
    chk("t6_e1_id0", 64'(disp_ray_id[31:0]), 64'd0);
    tick();
    chk("t6_e2_valid", 64'(disp_valid), 64'd2);
    chk("t6_e2_id1", 64'(disp_ray_id[63:32]), 64'd1);
    tick();
    chk("t6_e3_valid", 64'(disp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
